// File: rtl/pc_target_pkg.sv
// pc_target_pkg
// Shared definitions for the program-counter unit.
//   pc_mode_e    : next-PC source selection (sequential, branch, jump, register-jump)
//   PC_MODE_W    : width of the mode field
//   pc_inc_bytes : instruction size in bytes for a given alignment shift
package pc_target_pkg;

    localparam int unsigned PC_MODE_W = 2;

    typedef enum logic [PC_MODE_W-1:0] {
        PCM_SEQ    = 2'd0,
        PCM_BRANCH = 2'd1,
        PCM_JUMP   = 2'd2,
        PCM_JREG   = 2'd3
    } pc_mode_e;

    function automatic longint unsigned pc_inc_bytes(input int unsigned shift);
        return 64'd1 << shift;
    endfunction

endpackage

// File: rtl/pc_target_ras.sv
// pc_ras
// Circular return-address stack used by pc_target_unit when PC_RAS_EN is defined.
//   clk, rst   : clock, asynchronous active-high reset (clears pointer and count)
//   push       : store push_data as the new top entry
//   pop        : discard the top entry (ignored while empty)
//   push_data  : return address to store
//   top_data   : current top entry (only meaningful while not empty)
//   empty      : no valid entries
// Push+pop together on a non-empty stack overwrites the top in place.
// Pushing while full wraps the pointer onto the oldest entry.
module pc_ras #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign top_data = mem[top_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (do_pop && push) begin
            // replace in place: pointer and count unchanged
            top_ptr <= top_ptr;
        end else if (push) begin
            top_ptr <= top_ptr + 1'b1;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end else if (do_pop) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
        end
    end

    // storage carries no reset; entries are only read while count is nonzero
    always_ff @(posedge clk) begin
        if (do_pop && push) begin
            mem[top_ptr] <= push_data;
        end else if (push) begin
            mem[top_ptr + 1'b1] <= push_data;
        end
    end

endmodule

// File: rtl/pc_target_unit.sv
// pc_target_unit
// Registered program counter with next-PC selection for the single-cycle CPU.
// Optional feature macro: PC_RAS_EN (adds a RAS_DEPTH-entry return-address stack).
//   clk_i, rst_i : clock, asynchronous active-high reset
//   stall_i      : hold PC (and stack); suppresses misalign flag
//   mode_i       : 0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG
//   taken_i      : branch condition
//   jidx_i       : jump index (IMM_W bits)
//   boff_i       : signed branch word offset
//   rs_data_i    : register-jump target
//   link_i       : push return address on JUMP/JREG (stack build only)
//   ret_i        : pop return address on JREG (stack build only)
//   pc_o         : current PC (registered)
//   pc_plus_o    : pc_o + instruction size
//   misalign_o   : high the cycle after a JREG to a misaligned target
//   ras_empty_o  : return stack empty (tied high without the stack)
module pc_target_unit
    import pc_target_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       IMM_W     = 26,
    parameter int unsigned       SHIFT     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic [PC_MODE_W-1:0] mode_i,
    input  logic                 taken_i,
    input  logic [IMM_W-1:0]     jidx_i,
    input  logic [15:0]          boff_i,
    input  logic [ADDR_W-1:0]    rs_data_i,
    input  logic                 link_i,
    input  logic                 ret_i,
    output logic [ADDR_W-1:0]    pc_o,
    output logic [ADDR_W-1:0]    pc_plus_o,
    output logic                 misalign_o,
    output logic                 ras_empty_o
);

    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(pc_inc_bytes(SHIFT));
    localparam logic [ADDR_W-1:0] LOW_MASK = INC - ADDR_W'(1);
    // bits replaced by the jump index; when IMM_W+SHIFT == ADDR_W the shift
    // yields zero and the mask covers the whole word (no upper field kept)
    localparam logic [ADDR_W-1:0] JMP_MASK =
        (ADDR_W'(1) << (IMM_W + SHIFT)) - ADDR_W'(1);

    pc_mode_e          mode;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_plus;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] jreg_src;
    logic              jreg_misaligned;
    logic              misalign_q;

    assign mode        = pc_mode_e'(mode_i);
    assign pc_plus     = pc_q + INC;
    assign branch_off  = ADDR_W'($signed(boff_i)) << SHIFT;
    assign jump_target = (pc_plus & ~JMP_MASK) | (ADDR_W'(jidx_i) << SHIFT);

`ifdef PC_RAS_EN
    logic              ras_push;
    logic              ras_pop;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;

    assign ras_push = !stall_i && link_i && (mode == PCM_JUMP || mode == PCM_JREG);
    assign ras_pop  = !stall_i && ret_i && (mode == PCM_JREG);
    // an empty-stack return falls back to the register operand
    assign jreg_src = (ras_pop && !ras_empty) ? ras_top : rs_data_i;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top_data  (ras_top),
        .empty     (ras_empty)
    );

    assign ras_empty_o = ras_empty;
`else
    logic unused_ras;

    assign unused_ras  = link_i ^ ret_i ^ (RAS_DEPTH == 0);
    assign jreg_src    = rs_data_i;
    assign ras_empty_o = 1'b1;
`endif

    assign jreg_misaligned = |(jreg_src & LOW_MASK);

    always_comb begin
        pc_next = pc_plus;
        case (mode)
            PCM_SEQ:    pc_next = pc_plus;
            PCM_BRANCH: if (taken_i) pc_next = pc_plus + branch_off;
            PCM_JUMP:   pc_next = jump_target;
            PCM_JREG:   pc_next = jreg_src & ~LOW_MASK;
            default:    pc_next = pc_plus;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else if (stall_i) begin
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_next;
            misalign_q <= (mode == PCM_JREG) && jreg_misaligned;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus_o  = pc_plus;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_target_unit.sv
module tb_pc_target_unit;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 26;
    localparam int unsigned SH    = 2;
    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam int unsigned DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  mode  = 2'd0;
    logic        taken = 1'b0;
    logic [25:0] jidx  = '0;
    logic [15:0] boff  = '0;
    logic [31:0] rs    = '0;
    logic        link  = 1'b0;
    logic        ret   = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        mis;
    logic        rempty;

    int n_checks = 0;
    int n_fail   = 0;

    pc_target_unit #(
        .ADDR_W    (AW),
        .IMM_W     (IW),
        .SHIFT     (SH),
        .RESET_PC  (RPC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .stall_i     (stall),
        .mode_i      (mode),
        .taken_i     (taken),
        .jidx_i      (jidx),
        .boff_i      (boff),
        .rs_data_i   (rs),
        .link_i      (link),
        .ret_i       (ret),
        .pc_o        (pc),
        .pc_plus_o   (pc_plus),
        .misalign_o  (mis),
        .ras_empty_o (rempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc  = RPC;
    logic        m_mis = 1'b0;
    logic [31:0] m_ras [$];
    logic [31:0] m_seq;
    logic [31:0] m_src;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc  = RPC;
            m_mis = 1'b0;
            m_ras.delete();
        end else if (stall) begin
            m_mis = 1'b0;
        end else begin
            m_seq = m_pc + 32'd4;
            m_mis = 1'b0;
            case (mode)
                2'd0: m_pc = m_seq;
                2'd1: m_pc = taken ? m_seq + 32'(int'($signed(boff)) * 4) : m_seq;
                2'd2: begin
`ifdef PC_RAS_EN
                    if (link) begin
                        m_ras.push_back(m_seq);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
`endif
                    m_pc = (m_seq & 32'hF000_0000) | (32'(jidx) * 32'd4);
                end
                default: begin
                    m_src = rs;
`ifdef PC_RAS_EN
                    if (ret && m_ras.size() > 0) m_src = m_ras.pop_back();
                    if (link) begin
                        m_ras.push_back(m_seq);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
`endif
                    m_mis = (m_src % 4) != 0;
                    m_pc  = m_src - (m_src % 4);
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("pc_o", pc, m_pc);
        chk("pc_plus_o", pc_plus, m_pc + 32'd4);
        chk("misalign_o", 32'(mis), 32'(m_mis));
        chk("ras_empty_o", 32'(rempty), 32'(m_ras.size() == 0));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [1:0] m, input logic tk, input logic [25:0] j,
                        input logic [15:0] b, input logic [31:0] r,
                        input logic lk, input logic rt, input logic st);
        mode = m; taken = tk; jidx = j; boff = b; rs = r;
        link = lk; ret = rt; stall = st;
        @(posedge clk);
        #1;
        mode = 2'd0; taken = 1'b0; link = 1'b0; ret = 1'b0; stall = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async reset pc", pc, RPC);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #11;
        chk("reset pc", pc, 32'h0040_0000);
        chk("reset pc_plus", pc_plus, 32'h0040_0004);
        chk("reset misalign", 32'(mis), 32'd0);
        chk("reset ras_empty", 32'(rempty), 32'd1);
        rst = 1'b0;

        step(2'd0, 0, '0, '0, '0, 0, 0, 0); chk("seq1", pc, 32'h0040_0004);
        step(2'd0, 0, '0, '0, '0, 0, 0, 0); chk("seq2", pc, 32'h0040_0008);
        step(2'd0, 0, '0, '0, '0, 0, 0, 0); chk("seq3", pc, 32'h0040_000C);

        pulse_reset();
        step(2'd2, 0, 26'h010_0010, '0, '0, 0, 0, 0); chk("jump", pc, 32'h0040_0040);

        step(2'd3, 0, '0, '0, 32'h100, 0, 0, 0); chk("jreg 0x100", pc, 32'h100);
        step(2'd1, 1, '0, 16'hFFFF, '0, 0, 0, 0); chk("branch back", pc, 32'h100);
        step(2'd1, 0, '0, 16'hFFFF, '0, 0, 0, 0); chk("branch not taken", pc, 32'h104);
        step(2'd1, 1, '0, 16'h0010, '0, 0, 0, 0); chk("branch fwd", pc, 32'h148);

        step(2'd3, 0, '0, '0, 32'h1003, 0, 0, 0);
        chk("jreg misaligned pc", pc, 32'h1000);
        chk("misalign set", 32'(mis), 32'd1);
        step(2'd3, 0, '0, '0, 32'h1003, 0, 0, 1);
        chk("stall pc", pc, 32'h1000);
        chk("stall misalign", 32'(mis), 32'd0);
        step(2'd0, 0, '0, '0, '0, 0, 0, 0); chk("seq after stall", pc, 32'h1004);

        step(2'd3, 0, '0, '0, 32'hF000_0000, 0, 0, 0);
        step(2'd2, 0, 26'h3, '0, '0, 0, 0, 0); chk("jump keeps upper", pc, 32'hF000_000C);
        step(2'd3, 0, '0, '0, 32'hFFFF_FFFC, 0, 0, 0);
        step(2'd0, 0, '0, '0, '0, 0, 0, 0);
        chk("wrap pc", pc, 32'h0);
        chk("wrap pc_plus", pc_plus, 32'h4);

`ifndef PC_RAS_EN
        step(2'd3, 0, '0, '0, 32'h300, 1, 1, 0);
        chk("link/ret ignored pc", pc, 32'h300);
        chk("link/ret ignored empty", 32'(rempty), 32'd1);
`else
        pulse_reset();
        step(2'd3, 0, '0, '0, 32'h200, 0, 0, 0);
        step(2'd2, 0, 26'h400, '0, '0, 1, 0, 0);
        chk("jump link pc", pc, 32'h1000);
        chk("jump link not empty", 32'(rempty), 32'd0);
        step(2'd3, 0, '0, '0, 32'h900, 0, 1, 0);
        chk("ret pc", pc, 32'h204);
        chk("ret empty", 32'(rempty), 32'd1);

        step(2'd3, 0, '0, '0, 32'h10, 0, 0, 0);
        for (int i = 2; i <= 6; i++) step(2'd3, 0, '0, '0, 32'(i * 16), 1, 0, 0);
        step(2'd3, 0, '0, '0, 32'h700, 0, 1, 0); chk("pop1", pc, 32'h54);
        step(2'd3, 0, '0, '0, 32'h700, 0, 1, 0); chk("pop2", pc, 32'h44);
        step(2'd3, 0, '0, '0, 32'h700, 0, 1, 0); chk("pop3", pc, 32'h34);
        step(2'd3, 0, '0, '0, 32'h700, 0, 1, 0); chk("pop4", pc, 32'h24);
        step(2'd3, 0, '0, '0, 32'h700, 0, 1, 0); chk("pop empty fallback", pc, 32'h700);
        chk("empty after pops", 32'(rempty), 32'd1);

        step(2'd3, 0, '0, '0, 32'h80, 1, 0, 0);
        step(2'd3, 0, '0, '0, 32'h0, 1, 1, 0); chk("ret+link pc", pc, 32'h704);
        step(2'd3, 0, '0, '0, 32'h0, 0, 0, 1); chk("stalled ret pc", pc, 32'h704);
        chk("stalled ret keeps entry", 32'(rempty), 32'd0);
        step(2'd3, 0, '0, '0, 32'h0, 0, 1, 0); chk("replaced top", pc, 32'h84);
        chk("replace kept count", 32'(rempty), 32'd1);
`endif

        // asynchronous reset between edges after two pushes
        pulse_reset();
        step(2'd3, 0, '0, '0, 32'h10, 0, 0, 0);
        step(2'd3, 0, '0, '0, 32'h20, 1, 0, 0);
        step(2'd3, 0, '0, '0, 32'h30, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid reset pc", pc, 32'h0040_0000);
        chk("mid reset empty", 32'(rempty), 32'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        step(2'd0, 0, '0, '0, '0, 0, 0, 0); chk("first after reset", pc, 32'h0040_0004);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
